// File: rtl/que_arbiter_nrr.sv
// Registered N-way queue arbiter with held grants, fixed-priority or descending
// round-robin selection, programmable request polarity and optional hold limit.
module que_arbiter_nrr #(
  parameter int   N        = 9,
  parameter logic TARGET   = 1'b1,
  parameter logic MODE     = 1'b0,
  parameter int   MAX_HOLD = 0,
  localparam int  SW       = $clog2(N),
  localparam int  HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_done,
  output logic          o_gnt_vld,
  output logic [SW-1:0] o_gnt_sel,
  output logic [N-1:0]  o_gnt_oh,
  output logic          o_any_req,
  output logic          o_timeout
);

  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] last_q, last_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  logic [N-1:0]  req_act;
  logic [SW:0]   pick_idle;
  logic [SW:0]   pick_rel;
  logic          owner_req;
  logic          hold_hit;

  // Returns {found, index}; round-robin scans downward starting just below 'last'.
  function automatic logic [SW:0] pick(input logic [N-1:0] r, input logic [SW-1:0] last);
    logic          found;
    logic [SW-1:0] win;
    int            j;
    found = 1'b0;
    win   = '0;
    if (MODE == 1'b0) begin
      for (int k = 0; k < N; k++) begin
        if (r[k]) begin
          found = 1'b1;
          win   = SW'(k);
        end
      end
    end else begin
      for (int i = 1; i <= N; i++) begin
        j = int'(last) - i;
        if (j < 0) j = j + N;
        if (!found && r[j]) begin
          found = 1'b1;
          win   = SW'(j);
        end
      end
    end
    return {found, win};
  endfunction

  assign req_act   = ~(i_req ^ {N{TARGET}});
  assign o_any_req = |req_act;
  assign owner_req = req_act[sel_q];
  assign hold_hit  = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
  assign pick_idle = pick(req_act, last_q);
  // The releasing owner is masked so it cannot win the very next cycle.
  assign pick_rel  = pick(req_act & ~o_gnt_oh, sel_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_idle[SW]) begin
          state_d = GRANT;
          sel_d   = pick_idle[SW-1:0];
          last_d  = pick_idle[SW-1:0];
          cnt_d   = HW'(1);
        end
      end
      GRANT: begin
        if (!(i_done || !owner_req || hold_hit)) begin
          if (cnt_q != {HW{1'b1}}) cnt_d = cnt_q + HW'(1);
        end else begin
          to_d = hold_hit && !i_done && owner_req;
          if (pick_rel[SW]) begin
            sel_d  = pick_rel[SW-1:0];
            last_d = pick_rel[SW-1:0];
            cnt_d  = HW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_gnt_oh = '0;
    if (state_q == GRANT) o_gnt_oh[sel_q] = 1'b1;
  end

  assign o_gnt_vld = (state_q == GRANT);
  assign o_gnt_sel = sel_q;
  assign o_timeout = to_q;

endmodule

// File: doc/que_arbiter_nrr.md
Name: que_arbiter_nrr

Overview:
- Registered N-way queue arbiter; the sequential successor of the 9-input combinational priority decoder used in the queue arbitration path.
- Accepts N request lines and issues one held grant: index, one-hot, valid.
- Grant persists until the owner signals done, drops its request, or hits the hold limit.
- Supports fixed-priority mode (highest index wins) and round-robin mode (last winner gets lowest priority), with programmable request polarity.

Parameters:
- N, 9: number of requesters, 2..32.
- TARGET, 1'b1: active level of request bits; a bit equal to TARGET is a request.
- MODE, 1'b0: 0 = fixed priority (highest index wins); 1 = round-robin (descending rotation).
- MAX_HOLD, 0: maximum grant cycles before forced re-arbitration; 0 = unlimited. Width HW = max(1, $clog2(MAX_HOLD+1)).
- SW (derived, localparam), $clog2(N): grant index width.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_rst, input, 1: asynchronous reset, active-high.
- i_req, input, N: request vector; bit k requests when i_req[k] == TARGET.
- i_done, input, 1: owner releases grant this cycle (end of transfer); ignored when no grant.
- o_gnt_vld, output, 1: a grant is active.
- o_gnt_sel, output, SW: index of granted requester.
- o_gnt_oh, output, N: one-hot grant, all-zero when o_gnt_vld = 0.
- o_any_req, output, 1: combinational; high when any i_req bit == TARGET.
- o_timeout, output, 1: one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async assert, sync-free effect):
  - o_gnt_vld = 0, o_gnt_sel = 0, o_gnt_oh = 0, o_timeout = 0.
  - Hold counter = 0, last-winner pointer = 0, state = IDLE.
- Internal request vector r[k] = (i_req[k] == TARGET).
- Selection function sel(r, last):
  - MODE 0: highest k with r[k] set.
  - MODE 1: scan k = last-1, last-2, …, 0, N-1, …, last (mod N); first set bit wins.
  - With last = 0 after reset, MODE 1 order is N-1..0, identical to MODE 0.
  - No bit set: no winner.
- State IDLE:
  - If any r set at edge t: grant registered at t+1 (1-cycle latency).
  - At that edge: o_gnt_sel = winner, o_gnt_oh = 1<<winner, o_gnt_vld = 1, last = winner, counter = 1, state → GRANT.
- State GRANT, release condition rel = i_done | ~r[o_gnt_sel] | (MAX_HOLD != 0 && counter == MAX_HOLD).
  - If rel is false: hold the grant and increment the counter; it saturates at MAX_HOLD, and does not wrap when MAX_HOLD = 0.
  - If rel is true, back-to-back re-arbitration at the same edge:
    - Evaluate the winner with the current owner's bit masked out (r & ~o_gnt_oh).
    - MODE 1 also uses last = current owner.
    - If a winner exists, grant it next cycle with no bubble and counter = 1.
    - Otherwise o_gnt_vld = 0, o_gnt_oh = 0, state → IDLE, and o_gnt_sel keeps its last value.
- Masking the owner guarantees the released owner cannot win the immediately following cycle, even in MODE 0.
  - It may win again after any other grant or an idle cycle.
- o_timeout = 1 for exactly the cycle after a release whose only cause was the MAX_HOLD limit (i_done = 0 and request still set); 0 otherwise.
- Requests arriving or dropping in non-owner bits during GRANT do not affect the current grant.
- Reset asserted mid-grant: all outputs go to reset values immediately (asynchronous); arbitration restarts from IDLE after deassertion.
- o_gnt_oh always equals (o_gnt_vld ? 1<<o_gnt_sel : 0).
- o_gnt_vld never asserts with all requests inactive at the preceding edge.

Test Plan:
- N=9, MODE 0, TARGET 1: i_req = 9'h0A4 at cycle 0 → cycle 1 o_gnt_vld = 1, o_gnt_sel = 7, o_gnt_oh = 9'h080; hold for 5 cycles, then pulse i_done → next cycle o_gnt_sel = 5 (owner 7 masked).
- MODE 1, all 9 requests held high with i_done pulsed each grant → grant sequence 8, 7, 6, …, 0, 8 with no idle bubbles.
- TARGET 0: i_req = 9'h1FE → grant sel = 0; then drop the request (bit 0 → 1) → o_gnt_vld = 0 one cycle later.
- MAX_HOLD = 4, MODE 1, requests 3 and 1 held, no i_done → sel 3 for 4 cycles, o_timeout pulse, then sel 1 for 4 cycles, then 3; i_done never required.
- Assert i_rst asynchronously mid-grant (between edges) → outputs clear immediately; release with i_req = 9'h010 → grant sel 4 one cycle after the first post-reset edge.
- Owner drops request in the same cycle another bit rises → new bit granted the next cycle; verify the o_gnt_oh/o_gnt_sel consistency invariant every cycle.
